// File: rtl/piso_pkg.sv
// Shared types for the parallel-in / serial-out transmitter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, MSB-first shift register with zero fill.
// Synchronous controls with priority clr > load > shift.
module piso_shreg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   always_comb begin
      shreg_d = shreg_q;
      if (clr) begin
         shreg_d = '0;
      end else if (load) begin
         shreg_d = d;
      end else if (shift) begin
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer.sv
// Serial transmitter: accepts a WIDTH-bit word on valid/ready and sends it MSB first,
// one bit per shift_en cycle, with seamless back-to-back frames.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_last,
   output state_t           dbg_state_o
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   // Handshake: a word transfers on a rising edge where in_valid && in_ready.
   // in_ready is combinational from state, cnt, shift_en and rst; never from in_valid.

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_shift;
   logic             at_last;
   logic             accept;
   logic             sr_clr, sr_load, sr_shift;
   logic             sr_msb;

   always_comb begin
      is_shift = (state_q == SHIFT);
      at_last  = is_shift && (cnt_q == CNT_LAST);
      in_ready = !rst && (!is_shift || (at_last && shift_en));
      accept   = in_valid && in_ready;

      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_clr   = 1'b0;
      sr_load  = 1'b0;
      sr_shift = 1'b0;

      if (rst) begin
         state_d = IDLE;
         cnt_d   = '0;
         sr_clr  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sr_load = 1'b1;
                  cnt_d   = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  if (!at_last) begin
                     sr_shift = 1'b1;
                     cnt_d    = cnt_q + 1'b1;
                  end else if (accept) begin
                     // Next word replaces the last bit with no idle gap.
                     sr_load = 1'b1;
                     cnt_d   = '0;
                  end else begin
                     sr_clr  = 1'b1;
                     cnt_d   = '0;
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               sr_clr  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   piso_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk  (clk),
      .clr  (sr_clr),
      .load (sr_load),
      .shift(sr_shift),
      .d    (in_data),
      .msb  (sr_msb)
   );

   assign ser_valid   = is_shift;
   assign ser_out     = is_shift && sr_msb;
   assign frame_last  = at_last;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed scoreboard bench for piso_serializer at WIDTH=4 and WIDTH=8.
module tb_piso_serializer;
   import piso_pkg::*;

   logic       clk = 1'b0;
   logic       rst, shift_en;
   logic       in_valid, in_ready, ser_out, ser_valid, frame_last;
   logic [3:0] in_data;
   state_t     dbg_state;
   logic       in_valid8, in_ready8, ser_out8, ser_valid8, frame_last8;
   logic [7:0] in_data8;
   state_t     dbg_state8;

   int         vectors = 0;
   int         miscompares = 0;
   int         valid_cnt = 0;
   logic [1:0] exp_q[$];   // {frame_last, ser_out}
   logic [1:0] exp8_q[$];
   logic [1:0] item_m, item8_m;
   logic [3:0] sipo, sipo_frame;
   logic       fl_seen;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .shift_en(shift_en), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
      .frame_last(frame_last), .dbg_state_o(dbg_state)
   );

   piso_serializer #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .shift_en(shift_en), .in_valid(in_valid8), .in_data(in_data8),
      .in_ready(in_ready8), .ser_out(ser_out8), .ser_valid(ser_valid8),
      .frame_last(frame_last8), .dbg_state_o(dbg_state8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream 4-stage SIPO clocked on the same enables; snapshot taken on the last bit.
   always @(posedge clk) begin
      if (shift_en) begin
         sipo <= {sipo[2:0], ser_out};
         if (ser_valid && frame_last) sipo_frame <= {sipo[2:0], ser_out};
      end
   end

   always @(negedge clk) begin
      if (ser_valid === 1'b1) valid_cnt++;
      if (ser_valid === 1'b1 && shift_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_bit", 32'd1, 32'd0);
         end else begin
            item_m = exp_q.pop_front();
            check("ser_out", 32'(ser_out), 32'(item_m[0]));
            check("frame_last", 32'(frame_last), 32'(item_m[1]));
         end
      end else if (ser_valid === 1'b0) begin
         check("idle_zero", 32'({ser_out, frame_last}), 32'd0);
      end
   end

   always @(negedge clk) begin
      if (ser_valid8 === 1'b1 && shift_en) begin
         if (exp8_q.size() == 0) begin
            check("unexpected_bit8", 32'd1, 32'd0);
         end else begin
            item8_m = exp8_q.pop_front();
            check("ser_out8", 32'(ser_out8), 32'(item8_m[0]));
            check("frame_last8", 32'(frame_last8), 32'(item8_m[1]));
         end
      end
   end

   task automatic send_word(input logic [3:0] d, output logic fl_at_accept);
      logic ok;
      ok = 1'b0;
      fl_at_accept = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            fl_at_accept = frame_last;
            break;
         end
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      for (int b = 3; b >= 0; b--) exp_q.push_back({(b == 0), d[b]});
      #1;
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(0, 15));
   endtask

   task automatic send_word8(input logic [7:0] d);
      logic ok;
      ok = 1'b0;
      in_valid8 = 1'b1;
      in_data8  = d;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready8) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout8", 32'd0, 32'd1);
      @(posedge clk);
      for (int b = 7; b >= 0; b--) exp8_q.push_back({(b == 0), d[b]});
      #1;
      in_valid8 = 1'b0;
      in_data8  = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_idle(input string name);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!ser_valid && !ser_valid8) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check({name, "_idle_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; shift_en = 1'b1;
      in_valid = 1'b0; in_data = '0;
      in_valid8 = 1'b0; in_data8 = '0;

      // Reset held for two cycles
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_ser_out", 32'(ser_out), 32'd0);
      check("rst_frame_last", 32'(frame_last), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // 1: single word
      valid_cnt = 0;
      send_word(4'b1011, fl_seen);
      wait_idle("t1");
      check("t1_valid_cycles", 32'(valid_cnt), 32'd4);
      check("t1_sipo", 32'(sipo_frame), 32'b1011);

      // 2: back-to-back
      valid_cnt = 0;
      send_word(4'b1100, fl_seen);
      send_word(4'b0101, fl_seen);
      check("t2_accept_on_last", 32'(fl_seen), 32'd1);
      wait_idle("t2");
      check("t2_valid_cycles", 32'(valid_cnt), 32'd8);

      // 3: stall after the second bit
      valid_cnt = 0;
      send_word(4'b1001, fl_seen);
      @(posedge clk); #1;
      @(posedge clk); #1;
      shift_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t3_stall_ser_out", 32'(ser_out), 32'd0);
         check("t3_stall_valid", 32'(ser_valid), 32'd1);
         check("t3_stall_in_ready", 32'(in_ready), 32'd0);
         check("t3_stall_last", 32'(frame_last), 32'd0);
         @(posedge clk); #1;
      end
      shift_en = 1'b1;
      wait_idle("t3");
      check("t3_valid_cycles", 32'(valid_cnt), 32'd7);

      // 4: idle with in_data toggling, then IDLE accept while shift_en=0
      repeat (4) begin
         in_data = 4'($urandom_range(0, 15));
         @(negedge clk);
         check("t4_idle_valid", 32'(ser_valid), 32'd0);
         check("t4_idle_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
      end
      shift_en = 1'b0;
      send_word(4'b1010, fl_seen);
      repeat (2) begin
         @(negedge clk);
         check("t4_hold_ser_out", 32'(ser_out), 32'd1);
         check("t4_hold_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      shift_en = 1'b1;
      wait_idle("t4");

      // 5: mid-frame reset, with a word offered while rst is high
      send_word(4'b1111, fl_seen);
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 4'b1010;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      check("t5_rst_valid", 32'(ser_valid), 32'd0);
      check("t5_rst_ser_out", 32'(ser_out), 32'd0);
      check("t5_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("t5_release_in_ready", 32'(in_ready), 32'd1);
      check("t5_word_not_taken", 32'(ser_valid), 32'd0);
      @(posedge clk); #1;
      send_word(4'b0110, fl_seen);
      wait_idle("t5");

      // 6: WIDTH=8
      send_word8(8'hA5);
      wait_idle("t6");

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("exp8_q_drained", 32'(exp8_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
